// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DACC = 2'b01,
    IACC = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between pipeline, arbiter and RAM model.
// The slave modport is the arbiter's view; master is the pipeline + RAM environment.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      ihit;
  word_t     iload;
  logic      dhit;
  word_t     dload;
  word_t     ramaddr;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      merr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramaddr, ramREN, ramWEN, ramstore, merr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramaddr, ramREN, ramWEN, ramstore, merr
  );

endinterface

// File: rtl/arb_timeout.sv
// Access watchdog for mem_arbiter; only instantiated when MEM_ARB_TIMEOUT_EN is defined.
// expired is high once TIMEOUT-1 non-ACCESS cycles have been counted since clr.
module arb_timeout #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_r;

  // Wait-cycle counter, held at zero while the arbiter is idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_r <= CNT_ZERO;
    end else if (clr) begin
      count_r <= CNT_ZERO;
    end else if (en) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Data-priority arbiter of fetch and data requests onto a single-ported RAM.
// Define MEM_ARB_TIMEOUT_EN to abort accesses left un-ACCESSed for TIMEOUT cycles.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  arb_state_t state_r;
  word_t      addr_r;
  word_t      store_r;
  logic       wen_r;
  logic       ren_r;

  logic       ihit_s;
  logic       dhit_s;
  logic       merr_s;
  logic       done_s;
  logic       expired_s;
  logic       tmo_clr_s;
  logic       tmo_en_s;

  assign tmo_clr_s = (state_r == IDLE);
  assign tmo_en_s  = (state_r != IDLE) && (bus.ramstate != ACCESS);

`ifdef MEM_ARB_TIMEOUT_EN
  arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (tmo_clr_s),
    .en      (tmo_en_s),
    .expired (expired_s)
  );
`else
  assign expired_s = 1'b0;
`endif

  // Completion decode; gated by RST so a reset cycle never reports a hit or error.
  always_comb begin
    ihit_s = 1'b0;
    dhit_s = 1'b0;
    merr_s = 1'b0;
    done_s = 1'b0;
    if (!RST && (state_r != IDLE)) begin
      if (bus.ramstate == ACCESS) begin
        ihit_s = (state_r == IACC);
        dhit_s = (state_r == DACC);
        done_s = 1'b1;
      end else if ((bus.ramstate == ERROR) || expired_s) begin
        merr_s = 1'b1;
        done_s = 1'b1;
      end else begin
        done_s = 1'b0;
      end
    end else begin
      done_s = 1'b0;
    end
  end

  // Arbiter FSM; RAM-side outputs are registered and cleared on every return to IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      addr_r  <= 32'h0000_0000;
      store_r <= 32'h0000_0000;
      wen_r   <= 1'b0;
      ren_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.dREN || bus.dWEN) begin
            state_r <= DACC;
            addr_r  <= bus.daddr;
            store_r <= bus.dstore;
            wen_r   <= bus.dWEN;
            ren_r   <= !bus.dWEN;
          end else if (bus.iREN) begin
            state_r <= IACC;
            addr_r  <= bus.iaddr;
            store_r <= 32'h0000_0000;
            wen_r   <= 1'b0;
            ren_r   <= 1'b1;
          end else begin
            state_r <= IDLE;
            addr_r  <= 32'h0000_0000;
            store_r <= 32'h0000_0000;
            wen_r   <= 1'b0;
            ren_r   <= 1'b0;
          end
        end
        DACC, IACC: begin
          // The forced IDLE cycle after completion stops a just-dropped request being re-served.
          if (done_s) begin
            state_r <= IDLE;
            addr_r  <= 32'h0000_0000;
            store_r <= 32'h0000_0000;
            wen_r   <= 1'b0;
            ren_r   <= 1'b0;
          end else begin
            state_r <= state_r;
            addr_r  <= addr_r;
            store_r <= store_r;
            wen_r   <= wen_r;
            ren_r   <= ren_r;
          end
        end
        default: begin
          state_r <= IDLE;
          addr_r  <= 32'h0000_0000;
          store_r <= 32'h0000_0000;
          wen_r   <= 1'b0;
          ren_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ramaddr  = addr_r;
  assign bus.ramstore = store_r;
  assign bus.ramREN   = ren_r;
  assign bus.ramWEN   = wen_r;

  assign bus.ihit     = ihit_s;
  assign bus.dhit     = dhit_s;
  assign bus.merr     = merr_s;
  assign bus.iload    = ihit_s ? bus.ramload : 32'h0000_0000;
  assign bus.dload    = dhit_s ? bus.ramload : 32'h0000_0000;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Arbitrates the pipeline's instruction-fetch and data-memory requests onto the single-ported RAM.
- Returns the one-cycle `ihit`/`dhit` completion pulses that the hazard unit uses to stall and advance pipeline stages.
- Sits between the datapath request outputs and the RAM model.
- Data requests have strict priority over fetches.

## Interface
Parameters:
- `TIMEOUT`, 64, cycles a RAM access may remain un-ACCESSed before abort (only with `MEM_ARB_TIMEOUT_EN`)

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  clock; all state changes on rising edge
- `RST`  in  1  synchronous, active-high reset
- `iREN`  in  1  instruction read request (level, held until `ihit`)
- `iaddr`  in  32  fetch address
- `dREN`  in  1  data read request (level, held until `dhit`)
- `dWEN`  in  1  data write request (level, held until `dhit`)
- `daddr`  in  32  data address
- `dstore`  in  32  write data
- `ihit`  out  1  fetch complete, one-cycle pulse
- `iload`  out  32  fetched word, valid when `ihit`
- `dhit`  out  1  data access complete, one-cycle pulse
- `dload`  out  32  read word, valid when `dhit` for a read
- `ramaddr`  out  32  RAM address
- `ramREN`  out  1  RAM read strobe
- `ramWEN`  out  1  RAM write strobe
- `ramstore`  out  32  RAM write data
- `ramload`  in  32  RAM read data
- `ramstate`  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR
- `merr`  out  1  access aborted (ERROR or timeout), one-cycle pulse

## Operation
- FSM states: IDLE, DACC, IACC.
- IDLE:
  - `dREN|dWEN` → DACC, latching `daddr`, `dstore` and `dWEN`.
  - Otherwise `iREN` → IACC, latching `iaddr`.
  - Otherwise stay in IDLE.
- `dREN` and `dWEN` both high is treated as a write.
- DACC: drive `ramaddr` = latched address; `ramWEN` = latched write flag; `ramREN` = !latched write flag; `ramstore` = latched data.
- IACC: drive `ramaddr` = latched fetch address, `ramREN`=1, `ramWEN`=0.
- In DACC or IACC:
  - BUSY/FREE: hold the state.
  - ACCESS: pulse the matching hit, present `ramload` on the matching load output, → IDLE.
  - ERROR: pulse `merr`, no hit, → IDLE. The requester retries because its request is still asserted.
- The mandatory IDLE cycle after every completion prevents re-servicing a request that the pipeline drops on the hit edge.
- Request inputs are ignored outside IDLE. A request that changes mid-access does not alter the access in flight.
- Outputs in IDLE: all RAM strobes 0, `ramaddr`/`ramstore` 0, hits 0, loads 0.

## Timing
- Reset values: state IDLE; all outputs 0; latched address/data/write flag 0; timeout counter 0.
- Reset mid-access drops the access immediately. No hit is produced and strobes are 0 in the following cycle.
- Hit/`merr` are combinational from state and `ramstate`, asserted in the same cycle ACCESS is seen. Loads are combinational from `ramload`.
- Minimum request-to-hit latency: request seen in IDLE at cycle n → strobes from cycle n+1 → hit at n+1 if RAM returns ACCESS immediately.
- Latency is n+1+k for k BUSY cycles.
- Back-to-back requests: the next access starts 2 cycles after the previous hit (hit cycle, IDLE cycle, then next access).
- Simultaneous `iREN` and `dREN` in IDLE: data is served first; the fetch is served after the data hit plus the IDLE cycle.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to DACC/IACC and increments each cycle `ramstate`≠ACCESS.
  - When the count reaches `TIMEOUT`-1 without ACCESS: pulse `merr`, drop strobes, → IDLE.
- `MEM_ARB_TIMEOUT_EN` undefined: no counter, `TIMEOUT` unused, the FSM waits indefinitely. `merr` is driven only by ERROR.

## Structure
- `cpu_types_pkg` holds:
  - `word_t` (32-bit)
  - `ramstate_t` (FREE, BUSY, ACCESS, ERROR)
  - `arb_state_t` (IDLE, DACC, IACC)
- The timeout counter is the natural sub-module, `arb_timeout`.
  - Ports: `CLK`, `RST`, `clr`, `en`, `expired`.
  - Instantiated only under `MEM_ARB_TIMEOUT_EN`.
- The FSM and output muxing stay in `mem_arbiter`.

## Test plan
- Reset with all requests asserted, then deassert `RST` with RAM ACCESS. Required: all outputs 0 during reset; first cycle after reset is IDLE with no strobes.
- `iREN`=1, `iaddr`=0x0000_0040, RAM ACCESS immediately with `ramload`=0x2408_0005. Required: `ramREN`=1 and `ramaddr`=0x40 at cycle 1; `ihit`=1 and `iload`=0x2408_0005 at cycle 1; IDLE at cycle 2.
- `dWEN`=1, `daddr`=0x100, `dstore`=0xDEAD_BEEF, RAM BUSY 3 cycles then ACCESS. Required: `ramWEN`=1 and `ramstore`=0xDEADBEEF held cycles 1–4; single `dhit` pulse at cycle 4.
- `iREN` and `dREN` asserted together, RAM always ACCESS. Required: `dhit` at cycle 1, IDLE at cycle 2, `ihit` at cycle 3.
- RAM ERROR during DACC. Required: `merr` pulse, no `dhit`, retry begins 2 cycles later with the same address.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT`=8, RAM stuck BUSY. Required: `merr` at the 8th access cycle, strobes 0 the next cycle. Without the macro: still waiting after 100 cycles.
